// File: rtl/sra_pkg.sv
// Shared constants for the Smith-Waterman cell sequencer.
// - AU control encodings (the AU treats ctrl[1]=1 as max regardless of ctrl[0])
// - FSM state encodings, one AU operation per busy state
// - Default substitution and gap scores
package sra_pkg;

    localparam logic [1:0] AU_SUB = 2'b00;
    localparam logic [1:0] AU_ADD = 2'b01;
    localparam logic [1:0] AU_MAX = 2'b10;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S1   = 3'd1;
    localparam logic [2:0] ST_S2   = 3'd2;
    localparam logic [2:0] ST_S3   = 3'd3;
    localparam logic [2:0] ST_S4   = 3'd4;
    localparam logic [2:0] ST_S5   = 3'd5;
    localparam logic [2:0] ST_S6   = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    localparam int DEF_MATCH    = 2;
    localparam int DEF_MISMATCH = -1;
    localparam int DEF_GAP      = 1;

endpackage

// File: rtl/sw_cell_seq_au.sv
// Arithmetic unit shared by all steps of one cell computation.
// Ports:
//   ctrl  in  2      operation select (00 sub, 01 add, 1x max)
//   InA   in  msb+1  operand A
//   InB   in  msb+1  operand B
//   Out   out msb+1  result; add/sub wrap, max picks A on ties
module sw_cell_seq_au
    import sra_pkg::*;
#(
    parameter int msb = 15
) (
    input  logic [1:0]   ctrl,
    input  logic [msb:0] InA,
    input  logic [msb:0] InB,
    output logic [msb:0] Out
);

    logic [msb:0] diff;
    assign diff = InA - InB;

    always_comb begin
        Out = diff;
        if (ctrl[1]) begin
            // Sign of the wrapped difference decides; exact only while
            // operands stay well inside the signed range.
            Out = diff[msb] ? InB : InA;
        end else if (ctrl == AU_ADD) begin
            Out = InA + InB;
        end
    end

endmodule

// File: rtl/sw_cell_seq.sv
// Sequencer computing one Smith-Waterman cell score
//   H = max(0, diag+s, up-GAP, left-GAP), s = match ? MATCH : MISMATCH
// on a single AU, one AU operation per state (S1..S6), result held in DONE.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (diag_i, up_i, left_i, match_i)
//   out_valid / out_ready result handshake (h_o)
module sw_cell_seq
    import sra_pkg::*;
#(
    parameter int MSB      = 15,
    parameter int MATCH    = DEF_MATCH,
    parameter int MISMATCH = DEF_MISMATCH,
    parameter int GAP      = DEF_GAP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [MSB:0] diag_i,
    input  logic [MSB:0] up_i,
    input  logic [MSB:0] left_i,
    input  logic         match_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [MSB:0] h_o
);

    localparam logic [MSB:0] MATCH_V    = (MSB+1)'(MATCH);
    localparam logic [MSB:0] MISMATCH_V = (MSB+1)'(MISMATCH);
    localparam logic [MSB:0] GAP_V      = (MSB+1)'(GAP);

    logic [2:0]   state, state_nxt;
    logic [MSB:0] diag, up, left, acc, tmp;
    logic         match;
    logic         accept;

    logic [1:0]   ctrl;
    logic [1:0]   sel_a, sel_b;
    logic [MSB:0] au_a, au_b, au_out;

    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_DONE);

    // Per-state operand selects: A from {diag,up,left,acc}, B from {s,GAP,tmp,0}.
    always_comb begin
        ctrl  = AU_SUB;
        sel_a = 2'd3;
        sel_b = 2'd3;
        case (state)
            ST_S1:   begin ctrl = AU_ADD; sel_a = 2'd0; sel_b = 2'd0; end
            ST_S2:   begin ctrl = AU_SUB; sel_a = 2'd1; sel_b = 2'd1; end
            ST_S3:   begin ctrl = AU_MAX; sel_a = 2'd3; sel_b = 2'd2; end
            ST_S4:   begin ctrl = AU_SUB; sel_a = 2'd2; sel_b = 2'd1; end
            ST_S5:   begin ctrl = AU_MAX; sel_a = 2'd3; sel_b = 2'd2; end
            ST_S6:   begin ctrl = AU_MAX; sel_a = 2'd3; sel_b = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        case (sel_a)
            2'd0:    au_a = diag;
            2'd1:    au_a = up;
            2'd2:    au_a = left;
            default: au_a = acc;
        endcase
        case (sel_b)
            2'd0:    au_b = match ? MATCH_V : MISMATCH_V;
            2'd1:    au_b = GAP_V;
            2'd2:    au_b = tmp;
            default: au_b = '0;
        endcase
    end

    sw_cell_seq_au #(.msb(MSB)) u_au (
        .ctrl (ctrl),
        .InA  (au_a),
        .InB  (au_b),
        .Out  (au_out)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_S1;
            ST_DONE: if (out_ready) state_nxt = in_valid ? ST_S1 : ST_IDLE;
            default: state_nxt = state + 3'd1;  // S1..S5 step, S6 -> DONE
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            diag  <= '0;
            up    <= '0;
            left  <= '0;
            match <= 1'b0;
            acc   <= '0;
            tmp   <= '0;
            h_o   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                diag  <= diag_i;
                up    <= up_i;
                left  <= left_i;
                match <= match_i;
            end
            if (state == ST_S1 || state == ST_S3 || state == ST_S5) acc <= au_out;
            if (state == ST_S2 || state == ST_S4) tmp <= au_out;
            // h_o only changes here, so it holds through DONE and the next cell.
            if (state == ST_S6) h_o <= au_out;
        end
    end

endmodule

// File: tb/tb_sw_cell_seq.sv
// Bench for sw_cell_seq: directed cells with literal results, backpressure,
// back-to-back and mid-operation reset, then randomized traffic against a
// behavioural model of the cell score.
module tb_sw_cell_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] diag_i = '0, up_i = '0, left_i = '0;
    logic        match_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] h_o;

    int checks = 0;
    int failures = 0;

    sw_cell_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .diag_i(diag_i), .up_i(up_i), .left_i(left_i), .match_i(match_i),
        .out_valid(out_valid), .out_ready(out_ready), .h_o(h_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Wrapped max: sign of the wrapped difference chooses.
    function automatic logic [15:0] wmax(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = a - b;
        return d[15] ? b : a;
    endfunction

    function automatic logic [15:0] cell_h(input logic [15:0] d, input logic [15:0] u,
                                           input logic [15:0] l, input logic m);
        int sd, su, sl, s, best;
        logic [15:0] s16;
        sd = int'($signed(d)); su = int'($signed(u)); sl = int'($signed(l));
        s  = m ? 2 : -1;
        if (sd > -8192 && sd < 8192 && su > -8192 && su < 8192 && sl > -8192 && sl < 8192) begin
            best = 0;
            if (sd + s > best) best = sd + s;
            if (su - 1 > best) best = su - 1;
            if (sl - 1 > best) best = sl - 1;
            return best[15:0];
        end
        // Outside the exact range the result is defined by the wrapped operations.
        s16 = m ? 16'd2 : 16'hFFFF;
        return wmax(wmax(wmax(d + s16, u - 16'd1), l - 16'd1), 16'd0);
    endfunction

    // ---------------- model / compare process ----------------
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          inflight = 0;
    logic [15:0] exp_h = '0;
    logic [15:0] last_h = '0;
    int          cur_lit = -1;   // literal expectation for the cell being offered
    int          exp_lit = -1;

    always @(negedge clk) begin
        bit ev, ir;
        cyc++;
        if (!rst_n) begin
            inflight = 0;
            last_h   = '0;
        end else begin
            ev = inflight && (cyc - acc_cyc >= 7);
            ir = !inflight || (ev && out_ready);
            chk("out_valid", {15'd0, out_valid}, {15'd0, ev});
            chk("in_ready", {15'd0, in_ready}, {15'd0, ir});
            if (ev) begin
                chk("h_model", h_o, exp_h);
                if (exp_lit >= 0) chk("h_literal", h_o, exp_lit[15:0]);
                last_h = exp_h;
            end else begin
                chk("h_hold", h_o, last_h);
            end
            if (ev && out_ready) inflight = 0;
            if (in_valid && ir) begin
                inflight = 1;
                acc_cyc  = cyc;
                exp_h    = cell_h(diag_i, up_i, left_i, match_i);
                exp_lit  = cur_lit;
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic put(input logic [15:0] d, input logic [15:0] u, input logic [15:0] l,
                       input logic m, input int lit);
        diag_i = d; up_i = u; left_i = l; match_i = m; cur_lit = lit;
        in_valid = 1'b1;
    endtask

    // Offer a cell and return #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [15:0] u, input logic [15:0] l,
                        input logic m, input int lit);
        bit got = 0;
        put(d, u, l, m, lit);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready never rose at %0t", $time);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!inflight) begin done = 1; break; end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL drain_timeout: result never delivered at %0t", $time);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Pin the model to hand-computed values.
        chk("model_match", cell_h(16'd5, 16'd3, 16'd0, 1'b1), 16'd7);
        chk("model_clamp", cell_h(16'd0, 16'd0, 16'd0, 1'b0), 16'd0);
        chk("model_up",    cell_h(16'd1, 16'd10, 16'd4, 1'b0), 16'd9);
        chk("model_left",  cell_h(16'd1, 16'd2, 16'd8, 1'b0), 16'd7);
        chk("model_wrap",  cell_h(16'h4000, 16'hC000, 16'h0001, 1'b1), 16'd0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_h", h_o, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        @(posedge clk); #1;

        // Directed cells
        send(16'd5, 16'd3, 16'd0, 1'b1, 7);   drain();
        send(16'd0, 16'd0, 16'd0, 1'b0, 0);   drain();
        send(16'd1, 16'd10, 16'd4, 1'b0, 9);  drain();
        send(16'd1, 16'd2, 16'd8, 1'b0, 7);   drain();
        send(16'h4000, 16'hC000, 16'h0001, 1'b1, 0); drain();

        // Backpressure: stall 5 cycles with a new cell offered, then release.
        rdy_mode = 2;
        send(16'd20, 16'd3, 16'd3, 1'b1, 22);
        for (int k = 0; k < 20 && !out_valid; k++) @(posedge clk);
        #1 put(16'd1, 16'd2, 16'd8, 1'b0, 7);
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
        send(16'd1, 16'd2, 16'd8, 1'b0, 7);
        drain();

        // Back-to-back with in_valid held
        send(16'd5, 16'd3, 16'd0, 1'b1, 7);
        send(16'd1, 16'd10, 16'd4, 1'b0, 9);
        drain();

        // Reset during S3 (h_o currently holds 9)
        send(16'd30, 16'd0, 16'd0, 1'b1, 32);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("midrst_h", h_o, 16'd0);
        chk("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send(16'd1, 16'd10, 16'd4, 1'b0, 9);  drain();

        // Randomized traffic with random output stalls
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            logic [15:0] d, u, l;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 9) < 7) begin
                d = 16'($signed($urandom_range(0, 200)) - 100);
                u = 16'($signed($urandom_range(0, 200)) - 100);
                l = 16'($signed($urandom_range(0, 200)) - 100);
            end else begin
                d = 16'($urandom); u = 16'($urandom); l = 16'($urandom);
            end
            send(d, u, l, 1'($urandom), -1);
        end
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
